fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the PC source and the synchronous instruction ROM. It owns the fetch PC and issues one ROM read per cycle. It absorbs the ROM's 1-cycle read latency with a one-entry skid buffer and presents instructions to decode over a valid/ready handshake. It handles branch/jump redirects with in-flight squashing, plus halt/resume for debug and single-step.

---
 rtl/fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer, sync-ROM latency skid, decode handshake.
// Optional macro FETCH_TRAP_EN: misaligned redirects trap to TRAP_PC.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned AW       = 6,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          halt_req,
   input  logic          redirect_valid,
   input  logic [31:0]   redirect_pc,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   input  logic [31:0]   rom_data,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [31:0]   inst,
   output logic [31:0]   inst_pc,
   output logic [31:0]   inst_npc,
   output logic          halted,
   output logic          misalign_err
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic        req_v_q, req_v_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        skid_v_q, skid_v_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        out_v_q, out_v_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        mis_q, mis_d;

   logic        issue;
   logic        out_free;
   logic        squash;
   logic [31:0] tgt_pc;
   logic        tgt_mis;
   logic        unused_bits;

   assign unused_bits = ^{TRAP_PC, redirect_pc[1:0]};

   // Redirect target: trap or mask misaligned low bits.
   always_comb begin
      tgt_mis = 1'b0;
      tgt_pc  = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_TRAP_EN
      tgt_mis = |redirect_pc[1:0];
      if (tgt_mis) begin
         tgt_pc = TRAP_PC;
      end
`endif
   end

   // Next-state logic for the BOOT/RUN/HALT sequencer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt_req) state_d = HALT;
         HALT:    if (!halt_req) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // Issue, response routing, skid and redirect squash.
   always_comb begin
      issue       = (state_q == RUN) && !skid_v_q && !redirect_valid;
      out_free    = !out_v_q || inst_ready;
      squash      = redirect_valid && (state_q != HALT);
      fpc_d       = fpc_q;
      req_v_d     = issue;
      req_pc_d    = req_pc_q;
      skid_v_d    = skid_v_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;
      out_v_d     = out_v_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      mis_d       = 1'b0;

      if (issue) begin
         fpc_d    = fpc_q + 32'd4;
         req_pc_d = fpc_q;
      end

      if (out_free) begin
         if (skid_v_q) begin
            out_v_d    = 1'b1;
            out_inst_d = skid_inst_q;
            out_pc_d   = skid_pc_q;
            skid_v_d   = req_v_q;
            if (req_v_q) begin
               skid_inst_d = rom_data;
               skid_pc_d   = req_pc_q;
            end
         end else if (req_v_q) begin
            out_v_d    = 1'b1;
            out_inst_d = rom_data;
            out_pc_d   = req_pc_q;
         end else begin
            out_v_d = 1'b0;
         end
      end else if (req_v_q) begin
         if (!skid_v_q) begin
            skid_v_d    = 1'b1;
            skid_inst_d = rom_data;
            skid_pc_d   = req_pc_q;
         end else begin
            // Both slots full: drop the word and refetch it later.
            fpc_d = req_pc_q;
         end
      end

      if (redirect_valid) begin
         fpc_d = tgt_pc;
         mis_d = tgt_mis;
         if (squash) begin
            req_v_d  = 1'b0;
            skid_v_d = 1'b0;
            out_v_d  = 1'b0;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BOOT;
         fpc_q       <= RESET_PC;
         req_v_q     <= 1'b0;
         req_pc_q    <= 32'd0;
         skid_v_q    <= 1'b0;
         skid_inst_q <= 32'd0;
         skid_pc_q   <= 32'd0;
         out_v_q     <= 1'b0;
         out_inst_q  <= 32'd0;
         out_pc_q    <= 32'd0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fpc_q       <= fpc_d;
         req_v_q     <= req_v_d;
         req_pc_q    <= req_pc_d;
         skid_v_q    <= skid_v_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
         out_v_q     <= out_v_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
         mis_q       <= mis_d;
      end
   end

   assign rom_en       = issue;
   assign rom_addr     = fpc_q[AW+1:2];
   assign inst_valid   = out_v_q;
   assign inst         = out_inst_q;
   assign inst_pc      = out_pc_q;
   assign inst_npc     = out_pc_q + 32'd4;
   assign misalign_err = mis_q;
   assign halted       = (state_q == HALT) && !req_v_q
                         && !skid_v_q && !out_v_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a synchronous ROM model.
// Define FETCH_TRAP_EN for both bench and design to cover the trap build.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        halt_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        rom_en;
   logic [5:0]  rom_addr;
   logic [31:0] rom_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_npc;
   logic        halted;
   logic        misalign_err;

   int checks   = 0;
   int failures = 0;

   fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_en         (rom_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_npc       (inst_npc),
      .halted         (halted),
      .misalign_err   (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [5:0] a);
      return {16'hC0DE, 10'd0, a};
   endfunction

   // Synchronous ROM: data appears the cycle after rom_en.
   always @(posedge clk) begin
      if (rom_en) rom_data <= rom_word(rom_addr);
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      halt_req = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      inst_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_pc(input logic [31:0] pc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (inst_valid && inst_pc == pc) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      halt_req = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      inst_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rom_en !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0
          || misalign_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl: got en=%b v=%b h=%b m=%b want 0000",
                  rom_en, inst_valid, halted, misalign_err);
      end
      checks++;
      if (inst !== 32'd0 || inst_pc !== 32'd0 || inst_npc !== 32'd4
          || rom_addr !== 6'd0) begin
         failures++;
         $display("FAIL reset_data: got inst=%h pc=%h npc=%h a=%h want 0 0 4 0",
                  inst, inst_pc, inst_npc, rom_addr);
      end
   endtask

   task automatic test_boot();
      rst = 1'b0;
      #1;
      checks++;
      if (rom_en !== 1'b0) begin
         failures++;
         $display("FAIL boot_noissue: got rom_en=%b want 0", rom_en);
      end
      @(negedge clk);
      checks++;
      if (rom_en !== 1'b1 || rom_addr !== 6'd0 || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot_issue: got en=%b a=%h v=%b want 1 0 0",
                  rom_en, rom_addr, inst_valid);
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || rom_addr !== 6'd1) begin
         failures++;
         $display("FAIL boot_lat: got v=%b a=%h want 0 1",
                  inst_valid, rom_addr);
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd0
          || inst !== rom_word(6'd0)) begin
         failures++;
         $display("FAIL boot_first: got v=%b pc=%h inst=%h want 1 0 %h",
                  inst_valid, inst_pc, inst, rom_word(6'd0));
      end
   endtask

   task automatic test_stream();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k)
             || inst !== rom_word(6'(k)) || inst_npc !== 32'(4 * k + 4)) begin
            failures++;
            $display("FAIL stream_%0d: got v=%b pc=%h inst=%h npc=%h want pc=%h",
                     k, inst_valid, inst_pc, inst, inst_npc, 4 * k);
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      logic [31:0] exp;
      do_reset();
      wait_pc(32'd8, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL stall_start: got no pc 8 want pc 8");
      end
      inst_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'd8
             || inst !== rom_word(6'd2) || rom_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h en=%b want 1 8 %h 0",
                     s, inst_valid, inst_pc, inst, rom_en, rom_word(6'd2));
         end
      end
      inst_ready = 1'b1;
      exp = 32'd12;
      for (int i = 0; i < 12 && exp != 32'd28; i++) begin
         @(negedge clk);
         if (inst_valid) begin
            checks++;
            if (inst_pc !== exp || inst !== rom_word(exp[7:2])) begin
               failures++;
               $display("FAIL stall_resume: got pc=%h inst=%h want pc=%h",
                        inst_pc, inst, exp);
            end
            exp = exp + 32'd4;
         end
      end
      checks++;
      if (exp !== 32'd28) begin
         failures++;
         $display("FAIL stall_drain: got next=%h want 1c", exp);
      end
   endtask

   task automatic test_redirect();
      bit ok;
      do_reset();
      wait_pc(32'd8, ok);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      #1;
      checks++;
      if (!ok || rom_en !== 1'b0) begin
         failures++;
         $display("FAIL redir_noissue: got ok=%b en=%b want 1 0", ok, rom_en);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 6'h10) begin
         failures++;
         $display("FAIL redir_squash: got v=%b en=%b a=%h want 0 1 10",
                  inst_valid, rom_en, rom_addr);
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_bubble: got v=%b want 0", inst_valid);
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h40
          || inst !== rom_word(6'h10)) begin
         failures++;
         $display("FAIL redir_target: got v=%b pc=%h inst=%h want 1 40 %h",
                  inst_valid, inst_pc, inst, rom_word(6'h10));
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h44) begin
         failures++;
         $display("FAIL redir_next: got v=%b pc=%h want 1 44", inst_valid, inst_pc);
      end
   endtask

   task automatic test_halt();
      bit ok;
      do_reset();
      wait_pc(32'd8, ok);
      halt_req = 1'b1;
      @(negedge clk);
      checks++;
      if (!ok || inst_valid !== 1'b1 || inst_pc !== 32'd12
          || rom_en !== 1'b0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL halt_drain1: got ok=%b v=%b pc=%h en=%b h=%b want 1 1 c 0 0",
                  ok, inst_valid, inst_pc, rom_en, halted);
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd16 || halted !== 1'b0) begin
         failures++;
         $display("FAIL halt_drain2: got v=%b pc=%h h=%b want 1 10 0",
                  inst_valid, inst_pc, halted);
      end
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         checks++;
         if (halted !== 1'b1 || inst_valid !== 1'b0 || rom_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_idle_%0d: got h=%b v=%b en=%b want 1 0 0",
                     s, halted, inst_valid, rom_en);
         end
      end
      halt_req = 1'b0;
      @(negedge clk);
      checks++;
      if (halted !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 6'd5) begin
         failures++;
         $display("FAIL halt_resume: got h=%b en=%b a=%h want 0 1 5",
                  halted, rom_en, rom_addr);
      end
      wait_pc(32'd20, ok);
      checks++;
      if (!ok || inst !== rom_word(6'd5)) begin
         failures++;
         $display("FAIL halt_next: got ok=%b inst=%h want 1 %h",
                  ok, inst, rom_word(6'd5));
      end
   endtask

   task automatic test_rst_mid();
      bit ok;
      do_reset();
      wait_pc(32'd8, ok);
      rst = 1'b1;
      #1;
      checks++;
      if (!ok || inst_valid !== 1'b0 || inst_pc !== 32'd0 || inst !== 32'd0
          || inst_npc !== 32'd4 || rom_en !== 1'b0 || rom_addr !== 6'd0) begin
         failures++;
         $display("FAIL rst_async: got ok=%b v=%b pc=%h inst=%h npc=%h en=%b a=%h",
                  ok, inst_valid, inst_pc, inst, inst_npc, rom_en, rom_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_pc(32'd0, ok);
      checks++;
      if (!ok || inst !== rom_word(6'd0)) begin
         failures++;
         $display("FAIL rst_restart: got ok=%b inst=%h want 1 %h",
                  ok, inst, rom_word(6'd0));
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd4) begin
         failures++;
         $display("FAIL rst_next: got v=%b pc=%h want 1 4", inst_valid, inst_pc);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      do_reset();
      wait_pc(32'd8, ok);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_pc(32'hFFFF_FFFC, ok);
      checks++;
      if (!ok || inst_npc !== 32'd0 || inst !== rom_word(6'h3F)) begin
         failures++;
         $display("FAIL wrap_last: got ok=%b npc=%h inst=%h want 1 0 %h",
                  ok, inst_npc, inst, rom_word(6'h3F));
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin
         failures++;
         $display("FAIL wrap_zero: got v=%b pc=%h want 1 0", inst_valid, inst_pc);
      end
   endtask

   task automatic test_misalign();
      bit ok;
      logic        exp_mis;
      logic [31:0] exp_pc;
`ifdef FETCH_TRAP_EN
      exp_mis = 1'b1;
      exp_pc  = 32'h80;
`else
      exp_mis = 1'b0;
      exp_pc  = 32'h40;
`endif
      do_reset();
      wait_pc(32'd8, ok);
      redirect_valid = 1'b1;
      redirect_pc = 32'h42;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (!ok || misalign_err !== exp_mis) begin
         failures++;
         $display("FAIL mis_pulse: got ok=%b err=%b want 1 %b",
                  ok, misalign_err, exp_mis);
      end
      @(negedge clk);
      checks++;
      if (misalign_err !== 1'b0) begin
         failures++;
         $display("FAIL mis_clear: got err=%b want 0", misalign_err);
      end
      wait_pc(exp_pc, ok);
      checks++;
      if (!ok || inst !== rom_word(exp_pc[7:2])) begin
         failures++;
         $display("FAIL mis_target: got ok=%b pc=%h want pc=%h",
                  ok, inst_pc, exp_pc);
      end
   endtask

   initial begin
      rst = 1'b1;
      halt_req = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      inst_ready = 1'b1;
      test_reset();
      test_boot();
      test_stream();
      test_stall();
      test_redirect();
      test_halt();
      test_rst_mid();
      test_wrap();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
